adder_4bit_reg: RTL and testbench

// Registered 4-bit binary adder with carry-in/carry-out: Sum/Cout = A + B + Cin.

---
 rtl/adder_4bit_reg.sv | 53 +++++
 tb/tb_adder_4bit_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/adder_4bit_reg.sv
// Registered 4-bit ripple-carry adder: {Cout,Sum} = A + B + Cin, one cycle of latency,
// with signed overflow and zero flags captured alongside the sum.
module adder_4bit_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             ovf_c;

  // Ripple chain of full-adder cells; carry_c walks from bit 0 up to the carry-out.
  always_comb begin
    sum_c   = '0;
    carry_c = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i] = A[i] ^ B[i] ^ carry_c;
      carry_c  = (A[i] & B[i]) | (carry_c & (A[i] ^ B[i]));
    end
    ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
  end

  // Result registers update only on accepted operands; otherwise they hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= carry_c;
        Ovf  <= ovf_c;
        Zero <= (sum_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder_4bit_reg.sv
// Self-checking bench for adder_4bit_reg: directed table, spec sequences, exhaustive
// stream with mid-stream reset, and randomized traffic against an arithmetic model.
module tb_adder_4bit_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A, B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout, Ovf, Zero, out_valid;

  int checks   = 0;
  int failures = 0;

  // Model state: what the outputs should show after the most recent edge.
  logic [3:0] m_sum;
  logic       m_cout, m_ovf, m_zero, m_valid;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[7];

  adder_4bit_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B), .Cin(Cin),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Zero(Zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic view: unsigned total for Sum/Cout, signed total range for overflow.
  task automatic model_accept(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int total, sa, sb, stotal;
    total  = int'(a) + int'(b) + int'(cin);
    sa     = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb     = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    stotal = sa + sb + int'(cin);
    m_sum  = 4'(total % 16);
    m_cout = (total >= 16);
    m_ovf  = (stotal > 7) || (stotal < -8);
    m_zero = ((total % 16) == 0);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".Sum"},       int'(Sum),       int'(m_sum));
    check({tag, ".Cout"},      int'(Cout),      int'(m_cout));
    check({tag, ".Ovf"},       int'(Ovf),       int'(m_ovf));
    check({tag, ".Zero"},      int'(Zero),      int'(m_zero));
    check({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare #1 later.
  task automatic cycle(input string tag, input logic rst, input logic v,
                       input logic [3:0] a, input logic [3:0] b, input logic cin);
    rst_n = rst; in_valid = v; A = a; B = b; Cin = cin;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_sum = 4'd0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) model_accept(a, b, cin);
    end
    compare_all(tag);
  endtask

  initial begin
    vecs[0] = '{a: 4'd2,  b: 4'd3,  cin: 1'b0, sum: 4'd5,  cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd15, cin: 1'b1, sum: 4'd15, cout: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[2] = '{a: 4'd15, b: 4'd0,  cin: 1'b1, sum: 4'd0,  cout: 1'b1, ovf: 1'b0, zero: 1'b1};
    vecs[3] = '{a: 4'd7,  b: 4'd1,  cin: 1'b0, sum: 4'd8,  cout: 1'b0, ovf: 1'b1, zero: 1'b0};
    vecs[4] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, sum: 4'd0,  cout: 1'b1, ovf: 1'b1, zero: 1'b1};
    vecs[5] = '{a: 4'd8,  b: 4'd15, cin: 1'b0, sum: 4'd7,  cout: 1'b1, ovf: 1'b1, zero: 1'b0};
    vecs[6] = '{a: 4'd7,  b: 4'd0,  cin: 1'b1, sum: 4'd8,  cout: 1'b0, ovf: 1'b1, zero: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_valid = 1'b0;

    // Reset held two cycles while valid operands are presented.
    cycle("reset0", 1'b0, 1'b1, 4'd5, 4'd5, 1'b0);
    cycle("reset1", 1'b0, 1'b1, 4'd5, 4'd5, 1'b0);
    cycle("idle",   1'b1, 1'b0, 4'd9, 4'd9, 1'b1);

    // Directed table compared against hand-derived constants.
    for (int i = 0; i < 7; i++) begin
      rst_n = 1'b1; in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].cin;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.Sum", i),       int'(Sum),       int'(vecs[i].sum));
      check($sformatf("vec%0d.Cout", i),      int'(Cout),      int'(vecs[i].cout));
      check($sformatf("vec%0d.Ovf", i),       int'(Ovf),       int'(vecs[i].ovf));
      check($sformatf("vec%0d.Zero", i),      int'(Zero),      int'(vecs[i].zero));
      check($sformatf("vec%0d.out_valid", i), int'(out_valid), 1);
      m_valid = 1'b1;
      model_accept(vecs[i].a, vecs[i].b, vecs[i].cin);
    end

    // Back-to-back then idle: outputs hold the last accepted result.
    cycle("b2b0",  1'b1, 1'b1, 4'd1,  4'd1, 1'b0);
    cycle("b2b1",  1'b1, 1'b1, 4'd6,  4'd9, 1'b1);
    cycle("b2b2",  1'b1, 1'b1, 4'd4,  4'd3, 1'b1);
    cycle("hold0", 1'b1, 1'b0, 4'd15, 4'd15, 1'b1);
    check("hold0.Sum_last", int'(Sum), 8);
    cycle("hold1", 1'b1, 1'b0, 4'd0,  4'd0, 1'b0);

    // Exhaustive stream with a reset pulse in the middle.
    for (int k = 0; k < 512; k++) begin
      if (k == 256) begin
        cycle("midrst", 1'b0, 1'b1, 4'd3, 4'd4, 1'b1);
        check("midrst.ov_low", int'(out_valid), 0);
      end
      cycle($sformatf("exh%0d", k), 1'b1, 1'b1, 4'(k >> 5), 4'((k >> 1) & 15), 1'(k & 1));
    end

    // Randomized traffic with sporadic idle cycles.
    for (int r = 0; r < 300; r++) begin
      cycle($sformatf("rnd%0d", r), 1'b1, 1'($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
